// File: rtl/i2s_audio_pkg.sv
// Shared types and helpers for the I2S transmit audio path.
//   SAMPLE_W_DEF  : default mono sample width
//   FRAME_MCLKS   : mclk cycles per 8 kHz I2S frame
//   sched_state_t : source scheduler ownership state
//   to_i2s_word   : left-justifies a sample into a 32-bit slot word
package i2s_audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int FRAME_MCLKS  = 1536;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} sched_state_t;

  // sample arrives right-aligned in the low w bits; the serializer wants it
  // MSB-first in the slot, so shift it up and zero-fill below.
  function automatic logic [31:0] to_i2s_word(input logic [31:0] sample, input int w);
    return sample << (32 - w);
  endfunction

endpackage

// File: rtl/i2s_prio_enc.sv
// Fixed-priority encoder, index 0 highest.
//   req        : request vector
//   mask_below : only requests with index < mask_below are eligible
//                (N = all, owner index = preemption search, 0 = none)
//   onehot     : winning request, one-hot, 0 if none
//   valid      : some eligible request exists
module i2s_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [$clog2(N+1)-1:0] mask_below,
  output logic [N-1:0]           onehot,
  output logic                   valid
);

  localparam int IW = $clog2(N+1);

  // scan from the top so the lowest eligible index overwrites last
  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) < mask_below)) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_source_scheduler.sv
// Shares the I2S transmit path between NUM_SRC mono sources. On each
// serializer frame-accept pulse it picks an owner by fixed priority (with
// hold-off on empty frames and optional preemption), consumes one sample
// from it and presents that sample for the following frame.
//   mclk, rst  : clock, synchronous active-high reset
//   pdout_ack  : serializer latched pdout_l/pdout_r (one per frame)
//   pdout_l/r  : left-justified sample words for the next frame
//   src_valid  : per-source sample available
//   src_data   : packed samples, slice i = [i*SAMPLE_W +: SAMPLE_W]
//   src_ready  : one-cycle consume pulse to the granted source
//   mute       : load silence while still consuming
//   grant      : one-hot current owner, 0 when idle
//   busy       : in OWN state
//   underrun   : one-cycle pulse, owner had no sample at a frame
module i2s_tx_source_scheduler
  import i2s_audio_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int HOLD_FRAMES = 16,
  parameter int PREEMPT     = 0
) (
  input  logic                        mclk,
  input  logic                        rst,
  input  logic                        pdout_ack,
  output logic [31:0]                 pdout_l,
  output logic [31:0]                 pdout_r,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*SAMPLE_W-1:0] src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic                        mute,
  output logic [NUM_SRC-1:0]          grant,
  output logic                        busy,
  output logic                        underrun
);

  localparam int IW = $clog2(NUM_SRC + 1);
  localparam int MW = $clog2(HOLD_FRAMES + 1);

  generate
    if (HOLD_FRAMES < 1) begin : g_bad_hold
      $error("HOLD_FRAMES must be >= 1");
    end
    if (SAMPLE_W < 1 || SAMPLE_W > 32) begin : g_bad_width
      $error("SAMPLE_W must be in 1..32");
    end
  endgenerate

  sched_state_t         state, state_nxt;
  logic [MW-1:0]        miss_cnt, miss_nxt;
  logic [NUM_SRC-1:0]   grant_nxt, take, sel;
  logic                 sel_v, underrun_nxt;
  logic [IW-1:0]        owner_idx, mask;
  logic [SAMPLE_W-1:0]  take_data;
  logic [31:0]          pd_nxt;

  assign busy = (state == OWN);

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant[i]) owner_idx = IW'(i);
  end

  // one encoder serves both searches: all sources when idle, only those
  // above the owner when preemption is enabled, nothing otherwise
  always_comb begin
    if (state == IDLE)     mask = IW'(NUM_SRC);
    else if (PREEMPT != 0) mask = owner_idx;
    else                   mask = '0;
  end

  i2s_prio_enc #(.N(NUM_SRC)) u_enc (
    .req        (src_valid),
    .mask_below (mask),
    .onehot     (sel),
    .valid      (sel_v)
  );

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    miss_nxt     = miss_cnt;
    take         = '0;
    underrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sel_v) begin
          state_nxt = OWN;
          grant_nxt = sel;
          take      = sel;
          miss_nxt  = '0;
        end
      end
      OWN: begin
        if (sel_v) begin
          // only reachable with preemption: sel is above the owner
          grant_nxt = sel;
          take      = sel;
          miss_nxt  = '0;
        end else if (|(src_valid & grant)) begin
          take     = grant;
          miss_nxt = '0;
        end else begin
          underrun_nxt = 1'b1;
          miss_nxt     = miss_cnt + MW'(1);
          if (miss_nxt == MW'(HOLD_FRAMES)) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            miss_nxt  = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (take[i]) take_data = src_data[i*SAMPLE_W +: SAMPLE_W];
    // mute silences the slot but the sample is still consumed
    pd_nxt = (|take && !mute) ? to_i2s_word(32'(take_data), SAMPLE_W) : 32'h0;
  end

  always_ff @(posedge mclk) begin
    if (rst)            state <= IDLE;
    else if (pdout_ack) state <= state_nxt;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      grant     <= '0;
      miss_cnt  <= '0;
      pdout_l   <= '0;
      pdout_r   <= '0;
      src_ready <= '0;
      underrun  <= 1'b0;
    end else if (pdout_ack) begin
      grant     <= grant_nxt;
      miss_cnt  <= miss_nxt;
      pdout_l   <= pd_nxt;
      pdout_r   <= pd_nxt;
      src_ready <= take;
      underrun  <= underrun_nxt;
    end else begin
      src_ready <= '0;
      underrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_source_scheduler.sv
// Scoreboard bench: two instances share stimulus, dut_a with PREEMPT=0 and
// dut_b with PREEMPT=1. Each frame pushes the expected post-ack outputs of
// both; a monitor pops and compares on the cycle after every ack and checks
// that src_ready/underrun stay low on all other cycles.
module tb_i2s_tx_source_scheduler;

  typedef struct packed {
    logic [3:0]  grant;
    logic [3:0]  ready;
    logic [31:0] pdl;
    logic [31:0] pdr;
    logic        busy;
    logic        un;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic        mute = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [63:0] src_data = '0;

  logic [31:0] pdl_a, pdr_a, pdl_b, pdr_b;
  logic [3:0]  ready_a, grant_a, ready_b, grant_b;
  logic        busy_a, un_a, busy_b, un_b;
  obs_t        act_a, act_b;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic ack_d = 1'b0;
  logic mon_en = 1'b0;

  i2s_tx_source_scheduler #(.PREEMPT(0)) dut_a (
    .mclk(mclk), .rst(rst), .pdout_ack(ack), .pdout_l(pdl_a), .pdout_r(pdr_a),
    .src_valid(src_valid), .src_data(src_data), .src_ready(ready_a), .mute(mute),
    .grant(grant_a), .busy(busy_a), .underrun(un_a)
  );

  i2s_tx_source_scheduler #(.PREEMPT(1)) dut_b (
    .mclk(mclk), .rst(rst), .pdout_ack(ack), .pdout_l(pdl_b), .pdout_r(pdr_b),
    .src_valid(src_valid), .src_data(src_data), .src_ready(ready_b), .mute(mute),
    .grant(grant_b), .busy(busy_b), .underrun(un_b)
  );

  assign act_a = {grant_a, ready_a, pdl_a, pdr_a, busy_a, un_a};
  assign act_b = {grant_b, ready_b, pdl_b, pdr_b, busy_b, un_b};

  always #5 mclk = ~mclk;

  always @(posedge mclk) ack_d <= ack & ~rst;

  function automatic obs_t mk(input logic [3:0] g, input logic [3:0] r,
                              input logic [31:0] pd, input logic b, input logic u);
    return {g, r, pd, pd, b, u};
  endfunction

  function automatic exp_t both(input obs_t o);
    return {o, o};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got grant=%b ready=%b l=%h r=%h busy=%b un=%b, want grant=%b ready=%b l=%h r=%h busy=%b un=%b",
               name, act.grant, act.ready, act.pdl, act.pdr, act.busy, act.un,
               exp.grant, exp.ready, exp.pdl, exp.pdr, exp.busy, exp.un);
    end
  endtask

  // monitor
  always @(negedge mclk) begin
    exp_t e;
    if (ack_d) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_unexpected: ack seen with empty scoreboard");
      end else begin
        e = q.pop_front();
        check("frame_a", act_a, e.a);
        check("frame_b", act_b, e.b);
      end
    end else if (mon_en) begin
      vectors++;
      if ((ready_a | ready_b) !== 4'b0 || (un_a | un_b) !== 1'b0) begin
        miscompares++;
        $display("FAIL quiet_cycle: ready_a=%b ready_b=%b un_a=%b un_b=%b, want all 0",
                 ready_a, ready_b, un_a, un_b);
      end
    end
  end

  task automatic set_src(input int i, input logic [15:0] d);
    src_data[i*16 +: 16] = d;
  endtask

  // called at a negedge; returns at a negedge
  task automatic frame(input exp_t e);
    q.push_back(e);
    ack = 1'b1;
    @(negedge mclk);
    ack = 1'b0;
    repeat (3) @(negedge mclk);
  endtask

  initial begin
    repeat (3) @(negedge mclk);
    check("reset_a", act_a, mk(4'b0, 4'b0, 32'h0, 1'b0, 1'b0));
    check("reset_b", act_b, mk(4'b0, 4'b0, 32'h0, 1'b0, 1'b0));
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge mclk);

    // idle -> source 2 wins
    src_valid = 4'b0100;
    set_src(2, 16'h1234);
    frame(both(mk(4'b0100, 4'b0100, 32'h12340000, 1'b1, 1'b0)));

    // owner goes empty: 15 held misses, 16th releases
    src_valid = 4'b0000;
    for (int k = 1; k < 16; k++)
      frame(both(mk(4'b0100, 4'b0000, 32'h0, 1'b1, 1'b1)));
    frame(both(mk(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1)));

    // next ack picks up source 1
    src_valid = 4'b0010;
    set_src(1, 16'h0ABC);
    frame(both(mk(4'b0010, 4'b0010, 32'h0ABC0000, 1'b1, 1'b0)));

    // reset coincident with ack while owning: no ready, all cleared
    rst = 1'b1;
    ack = 1'b1;
    @(negedge mclk);
    ack = 1'b0;
    rst = 1'b0;
    check("rst_ack_a", act_a, mk(4'b0, 4'b0, 32'h0, 1'b0, 1'b0));
    check("rst_ack_b", act_b, mk(4'b0, 4'b0, 32'h0, 1'b0, 1'b0));
    repeat (2) @(negedge mclk);

    // back in IDLE: empty frame gives silence and no underrun
    src_valid = 4'b0000;
    frame(both(mk(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0)));

    // all request: source 0 wins, sign bit kept
    src_valid = 4'b1111;
    set_src(0, 16'h8000);
    set_src(1, 16'h0001);
    set_src(2, 16'h0002);
    set_src(3, 16'h0003);
    frame(both(mk(4'b0001, 4'b0001, 32'h80000000, 1'b1, 1'b0)));

    // mute consumes but silences, then normal output resumes
    src_valid = 4'b0001;
    set_src(0, 16'h7FFF);
    mute = 1'b1;
    frame(both(mk(4'b0001, 4'b0001, 32'h0, 1'b1, 1'b0)));
    mute = 1'b0;
    set_src(0, 16'h1111);
    frame(both(mk(4'b0001, 4'b0001, 32'h11110000, 1'b1, 1'b0)));

    // preemption: owner 2, then source 0 shows up
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    src_valid = 4'b0100;
    set_src(2, 16'h2222);
    frame(both(mk(4'b0100, 4'b0100, 32'h22220000, 1'b1, 1'b0)));
    src_valid = 4'b0101;
    set_src(2, 16'h3333);
    set_src(0, 16'h5555);
    frame({mk(4'b0100, 4'b0100, 32'h33330000, 1'b1, 1'b0),
           mk(4'b0001, 4'b0001, 32'h55550000, 1'b1, 1'b0)});
    // lower-priority source 2 must not take back ownership in dut_b
    set_src(2, 16'h4444);
    set_src(0, 16'h6666);
    frame({mk(4'b0100, 4'b0100, 32'h44440000, 1'b1, 1'b0),
           mk(4'b0001, 4'b0001, 32'h66660000, 1'b1, 1'b0)});
    // source 2 withdraws without a ready: a miss for dut_a only
    src_valid = 4'b0001;
    set_src(0, 16'h7777);
    frame({mk(4'b0100, 4'b0000, 32'h0, 1'b1, 1'b1),
           mk(4'b0001, 4'b0001, 32'h77770000, 1'b1, 1'b0)});

    repeat (4) @(negedge mclk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_tx_source_scheduler.md
Name: i2s_tx_source_scheduler

Overview:
- Shares the 8 kHz I2S transmit path between NUM_SRC mono sample sources, e.g. DTMF generator, prop sound player and voice playback.
- On every frame-accept pulse from the I2S serializer it grants ownership of the output by fixed priority, with hold and optional preemption.
- It consumes one sample from the owner and presents it as left/right 32-bit words for the following frame.
- It sits between the audio sources and the I2S serializer, in the mclk domain.

Parameters:
- NUM_SRC, 4: number of requesters; index 0 has the highest priority.
- SAMPLE_W, 16: source sample width, two's complement.
- HOLD_FRAMES, 16: consecutive empty frames before the owner is released.
- PREEMPT, 0: when 1, a higher-priority valid source takes ownership at the next frame.

Ports:
- mclk  in  1  12.288 MHz clock
- rst  in  1  reset
- pdout_ack  in  1  one-cycle pulse: serializer latched pdout_l/pdout_r, one per 1536 mclk
- pdout_l  out  32  left word for the next frame
- pdout_r  out  32  right word for the next frame
- src_valid  in  NUM_SRC  source i has a sample on its data slice
- src_data  in  NUM_SRC*SAMPLE_W  packed samples, slice i = [i*SAMPLE_W +: SAMPLE_W]
- src_ready  out  NUM_SRC  one-cycle consume pulse, at most one bit set
- mute  in  1  force silence, ownership unaffected
- grant  out  NUM_SRC  one-hot current owner, 0 when idle
- busy  out  1  high when in OWN state
- underrun  out  1  one-cycle pulse: owner had no sample at a frame

Behaviour:
- Interface: reset rst, synchronous, active-high; clock mclk.
- Reset values: pdout_l=0, pdout_r=0, src_ready=0, grant=0, busy=0, underrun=0, miss_cnt=0, state=IDLE.
- All decisions occur only on a cycle with pdout_ack=1. Results are registered, so they are visible the cycle after ack.
- The sample presented after ack N is transmitted in frame N+1. Fixed latency is one frame.
- Output word: pdout_l = pdout_r = {sample, (32-SAMPLE_W) zeros}, i.e. left-justified. Silence = 32'h0. If mute=1 at ack, silence is loaded but the sample is still consumed.
- Source handshake:
  - A source holds valid and data stable until it sees src_ready.
  - The sample is taken at the edge where ack is sampled. src_ready[i] is high for exactly the next cycle.
  - The source may present its next sample one cycle after src_ready.
- FSM IDLE, on ack:
  - If any src_valid is set, pick the lowest index p.
  - Set grant=onehot(p), go to OWN, consume p's sample, miss_cnt=0.
  - Otherwise load silence and stay in IDLE. No underrun in IDLE.
- FSM OWN (owner o), on ack:
  - If PREEMPT=1 and a valid source with index < o exists, switch grant to the lowest such index p. Consume p's sample, miss_cnt=0. o's sample is not consumed.
  - Else if src_valid[o]=1, consume o's sample and set miss_cnt=0.
  - Else load silence, pulse underrun, and increment miss_cnt. If the incremented value equals HOLD_FRAMES, go to IDLE with grant=0 and miss_cnt=0. A new owner can then be selected at the next ack, not the same one.
- Lower-priority sources never preempt. With PREEMPT=0 they wait until the owner is released.
- Source deasserts valid without a ready pulse: the scheduler tolerates it, and the frame counts as a miss.
- Between acks, changes to src_valid/src_data have no effect. A pdout_ack held high for multiple cycles is an illegal stimulus; each high cycle is treated as a frame.
- rst mid-operation: all state and outputs return to reset values on the next edge. No src_ready is issued on a reset edge, even if ack=1.
- miss_cnt width: $clog2(HOLD_FRAMES+1). HOLD_FRAMES>=1 is required (elaboration assertion).

Decomposition:
- Package i2s_audio_pkg holds:
  - SAMPLE_W_DEF=16, FRAME_MCLKS=1536
  - sched_state_t enum {IDLE, OWN}
  - function to_i2s_word(sample) for the left-justify
- Sub-module i2s_prio_enc: parameter N; inputs req[N-1:0] and mask_below (index limit); outputs onehot and valid. Purely combinational fixed-priority encoder, used for both idle selection and preemption search.

Test Plan:
- Idle then src_valid=4'b0100, data 16'h1234, ack -> next cycle grant=4'b0100, src_ready=4'b0100, pdout_l=pdout_r=32'h12340000, busy=1.
- Owner 2, src 2 empty for 16 acks -> underrun pulses 16 times, pdout=0 each frame. After the 16th ack grant=0 and busy=0; at ack 17 src 1 valid gets granted.
- PREEMPT=0, owner 2 streaming, src 0 asserts valid -> grant stays 4'b0100 until release. PREEMPT=1 -> at the next ack grant=4'b0001, src_ready=4'b0001, and src 2 sees no ready.
- Simultaneous src_valid=4'b1111 from IDLE -> src 0 wins. Data 16'h8000 -> pdout_l=32'h80000000, sign bit preserved.
- mute=1 with owner valid, data 16'h7FFF -> src_ready pulses and pdout=0. After mute=0, the next sample is output normally.
- rst asserted on the same cycle as pdout_ack while in OWN -> src_ready stays 0, all outputs are 0 next cycle, state=IDLE.
